// File: rtl/obc_challenge_pkg.sv
// Shared types and helpers for the OBC challenge link and its downstream checker.
// State encoding, LFSR geometry and the challenge/answer mapping live here.
package obc_challenge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        REPORT = 2'b10
    } state_t;

    localparam int LFSR_W     = 4;
    localparam int LFSR_TAP_A = 3;
    localparam int LFSR_TAP_B = 2;

    // Answer the OBC must compute for a given challenge.
    function automatic logic [LFSR_W-1:0] expected_answer(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] e;
        e[0] = ~q[0];
        e[1] = q[0] ^ q[1];
        e[2] = q[1] ^ q[2];
        e[3] = q[2] ^ q[3];
        return e;
    endfunction

endpackage

// File: rtl/challenge_lfsr.sv
// 4-bit Fibonacci LFSR that steps once per advance strobe.
// An all-zero seed would lock the register, so it is replaced by 0001.
module challenge_lfsr
    import obc_challenge_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 4'b1001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED_SAFE;
        end else if (advance) begin
            value <= {value[LFSR_W-2:0], value[LFSR_TAP_A] ^ value[LFSR_TAP_B]};
        end
    end

endmodule

// File: rtl/obc_challenge_link.sv
// Issues periodic pseudo-random challenges to the OBC and reports one verdict each.
// Optional OBC_CHALLENGE_STATS_EN adds a saturating fail_streak output.
//
// state  | meaning
// IDLE   | counting the inter-challenge period while enabled
// WAIT   | challenge presented, waiting for answer or timeout
// REPORT | one-cycle verdict strobe
module obc_challenge_link
    import obc_challenge_pkg::*;
#(
    parameter int               PERIOD_CYCLES  = 64,
    parameter int               TIMEOUT_CYCLES = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 4'b1001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [LFSR_W-1:0] question,
    output logic              question_valid,
    input  logic [LFSR_W-1:0] answer_obc,
    input  logic              answer_valid,
    output logic [LFSR_W-1:0] expected,
    output logic              result_valid,
    output logic              result_pass,
    output logic              result_timeout,
    output logic              busy
`ifdef OBC_CHALLENGE_STATS_EN
    ,
    output logic [3:0]        fail_streak
`endif
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [PW-1:0]     period_cnt;
    logic [TW-1:0]     timeout_cnt;
    logic [LFSR_W-1:0] lfsr_value;
    logic              launch;
    logic              finish;
    logic              timed_out;
    logic              verdict_pass;

    challenge_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (launch),
        .value   (lfsr_value)
    );

    // An answer in the terminal timeout cycle takes priority over the timeout.
    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        finish       = 1'b0;
        timed_out    = 1'b0;
        verdict_pass = 1'b0;
        case (state)
            IDLE: begin
                if (enable && period_cnt == PERIOD_LAST) begin
                    launch    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (answer_valid) begin
                    finish       = 1'b1;
                    verdict_pass = (answer_obc == expected);
                    state_nxt    = REPORT;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            period_cnt     <= '0;
            timeout_cnt    <= '0;
            question       <= '0;
            expected       <= '0;
            result_pass    <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                period_cnt <= (launch || !enable) ? '0 : period_cnt + PW'(1);
            end
            if (launch) begin
                question    <= lfsr_value;
                expected    <= expected_answer(lfsr_value);
                timeout_cnt <= '0;
            end else if (state == WAIT && !finish) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
            if (finish) begin
                result_pass    <= verdict_pass;
                result_timeout <= timed_out;
            end
        end
    end

`ifdef OBC_CHALLENGE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_streak <= '0;
        end else if (finish) begin
            if (verdict_pass) begin
                fail_streak <= '0;
            end else if (fail_streak != 4'hF) begin
                fail_streak <= fail_streak + 4'd1;
            end
        end
    end
`endif

    assign question_valid = (state == WAIT);
    assign result_valid   = (state == REPORT);
    assign busy           = (state == WAIT) || (state == REPORT);

endmodule

// File: doc/obc_challenge_link.md
Name: obc_challenge_link

Overview:
Upstream stage of the OBC error-checking state machine. Periodically issues a 4-bit pseudo-random challenge to the OBC over a valid/answer handshake, computes the expected answer locally, and waits a bounded time for the OBC reply. Delivers one registered verdict per challenge (pass / fail / timeout) to the downstream checker, which decides valid vs. shutdown.

Parameters:
PERIOD_CYCLES, 64, idle cycles between challenges while enabled (min 2)
TIMEOUT_CYCLES, 16, max cycles the OBC has to answer (min 1)
LFSR_SEED, 4'b1001, reset value of challenge LFSR; 4'b0000 is forced to 4'b0001

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  allows new challenges to start
question  out  4  challenge presented to the OBC
question_valid  out  1  high while a challenge awaits an answer
answer_obc  in  4  OBC response
answer_valid  in  1  OBC response strobe, one cycle
expected  out  4  locally computed answer for current/last challenge
result_valid  out  1  one-cycle verdict strobe
result_pass  out  1  answer_obc == expected; qualified by result_valid
result_timeout  out  1  no answer within TIMEOUT_CYCLES; qualified by result_valid
busy  out  1  high in WAIT and REPORT

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: state=IDLE, all outputs 0, period_cnt=0, timeout_cnt=0, lfsr=LFSR_SEED.
- LFSR: 4-bit Fibonacci, next = {lfsr[2:0], lfsr[3]^lfsr[2]}; period 15; never 0000.
- Expected answer: e[0]=~q[0]; e[1]=q[0]^q[1]; e[2]=q[1]^q[2]; e[3]=q[2]^q[3].
- IDLE: period_cnt increments while enable=1, clears to 0 when enable=0. On enable=1 and period_cnt==PERIOD_CYCLES-1: register question<=lfsr, expected<=f(lfsr), advance lfsr, clear period_cnt and timeout_cnt, go to WAIT. question_valid rises the following cycle.
- WAIT: question_valid=1; question/expected stable. answer_valid=1 -> result_pass<=(answer_obc==expected), result_timeout<=0, go to REPORT. Otherwise timeout_cnt increments; at timeout_cnt==TIMEOUT_CYCLES-1 -> result_pass<=0, result_timeout<=1, go to REPORT.
- Simultaneous answer_valid and timeout terminal count: answer wins.
- REPORT: result_valid=1 for exactly one cycle, question_valid=0; then IDLE. result_pass/result_timeout hold until the next verdict.
- Latency: answer_valid sampled in cycle N -> result_valid high in cycle N+1.
- answer_valid outside WAIT is ignored, with no side effects.
- enable dropping during WAIT does not abort; the challenge completes and reports.
- reset asserted in any state returns to reset values at the next edge; any in-flight challenge is discarded with no verdict.

Optional Feature:
OBC_CHALLENGE_STATS_EN
- Defined: adds output fail_streak[3:0]. Increments, saturating at 15, on each verdict with result_pass=0 (fail or timeout). Clears to 0 on a pass and on reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package obc_challenge_pkg contains:
  - state localparams IDLE=2'b00, WAIT=2'b01, REPORT=2'b10
  - LFSR width and tap constants
  - expected_answer function (shared with the downstream checker)
- Sub-module challenge_lfsr: 4-bit LFSR with advance strobe, seed parameter and zero-seed guard.

Test Plan:
- Reset with default params, enable=1 from cycle 0 -> question_valid rises at cycle 64 with question=1001, expected=1010.
- Answer 1010 two cycles after question_valid -> result_valid one cycle later, result_pass=1, result_timeout=0. Next challenge is 0011 with expected 0100.
- Answer 1011 to question 1001 -> result_pass=0, result_timeout=0. With OBC_CHALLENGE_STATS_EN defined, fail_streak goes 0->1.
- No answer -> result_timeout=1, result_pass=0, 16 cycles after question_valid rose (+1 cycle for REPORT). answer_valid on the terminal cycle instead -> verdict is pass or fail, not timeout.
- enable=0 mid-WAIT, then a correct answer -> verdict still issued, and no new challenge while enable=0. answer_valid pulses in IDLE -> no result_valid.
- reset in WAIT -> next cycle question_valid=0, busy=0, lfsr reseeded to 1001, no result_valid. LFSR_SEED=0000 -> first question 0001.
